// File: rtl/csa_acc_pkg.sv
// Shared constants and FSM state encoding for the carry-save accumulator.
package csa_acc_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 16;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        RESOLVE = 2'd1,
        HOLD    = 2'd2
    } state_t;

endpackage

// File: rtl/cla32_adder.sv
// 32-bit carry-lookahead adder built from eight 4-bit generate/propagate groups.
module cla32_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        cout
);

    localparam int unsigned GRP   = 4;
    localparam int unsigned NGRP  = 8;

    logic [31:0]     g;
    logic [31:0]     p;
    logic [NGRP-1:0] gg;
    logic [NGRP-1:0] gp;
    logic [NGRP-1:0] gc;
    logic            grp_run;
    logic            bit_run;

    assign g = a & b;
    assign p = a ^ b;

    // Group generate/propagate from the four bits of each group.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < NGRP; k++) begin
            gg[k] = g[GRP*k+3]
                  | (p[GRP*k+3] & g[GRP*k+2])
                  | (p[GRP*k+3] & p[GRP*k+2] & g[GRP*k+1])
                  | (p[GRP*k+3] & p[GRP*k+2] & p[GRP*k+1] & g[GRP*k]);
            gp[k] = &p[GRP*k +: GRP];
        end
    end

    // Lookahead across groups yields each group's carry-in and the carry out.
    always_comb begin
        gc      = '0;
        grp_run = 1'b0;
        for (int k = 0; k < NGRP; k++) begin
            gc[k]   = grp_run;
            grp_run = gg[k] | (gp[k] & grp_run);
        end
        cout = grp_run;
    end

    always_comb begin
        sum     = '0;
        bit_run = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if ((i % GRP) == 0) begin
                bit_run = gc[i/GRP];
            end
            sum[i]  = p[i] ^ bit_run;
            bit_run = g[i] | (p[i] & bit_run);
        end
    end

endmodule

// File: rtl/csa_structural.sv
// Bitwise 3:2 compressor: per-bit full adders, carry left unshifted (majority).
module csa_structural #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign carry[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: redundant S/C accumulation, CLA resolve on last beat.
module csa_accumulator
    import csa_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] s_q;
    logic [WIDTH-1:0] c_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] csa_sum;
    logic [WIDTH-1:0] csa_maj;
    logic [WIDTH-1:0] cla_sum;
    logic             cla_cout;
    logic             beat;

    csa_structural #(.WIDTH(WIDTH)) u_csa (
        .a     (s_q),
        .b     (c_q),
        .c     (in_data),
        .sum   (csa_sum),
        .carry (csa_maj)
    );

    cla32_adder u_cla (
        .a    (s_q),
        .b    (c_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    assign beat = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACC;
        end else begin
            state <= next_state;
        end
    end

    // Handshake signals decode from state alone.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACC: begin
                in_ready = 1'b1;
                if (beat && in_last) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                next_state = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = ACC;
                end
            end
            default: begin
                next_state = ACC;
            end
        endcase
    end

    // Dropped MSB carries and the final CLA carry together give exact overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            c_q       <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (beat) begin
                        s_q   <= csa_sum;
                        c_q   <= {csa_maj[WIDTH-2:0], 1'b0};
                        ovf_q <= ovf_q | csa_maj[WIDTH-1];
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                RESOLVE: begin
                    out_sum   <= cla_sum;
                    out_ovf   <= ovf_q | cla_cout;
                    out_count <= cnt_q;
                    s_q       <= '0;
                    c_q       <= '0;
                    ovf_q     <= 1'b0;
                    cnt_q     <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
